// File: rtl/vis_frame_buffer_if.sv
// rtl/vis_frame_buffer_if.sv - visibility packet stream toward readout/DMA
interface vis_frame_buffer_if #(
   parameter int WIDTH = 36
);
   logic [WIDTH-1:0] m_tdata;
   logic             m_tvalid;
   logic             m_tlast;
   logic             m_tready;

   modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
   modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/vis_frame_buffer.sv
// rtl/vis_frame_buffer.sv - ping-pong frame capture of visibilities, replayed as header + re/im packets
module vis_frame_buffer #(
   parameter int WIDTH = 36,
   parameter int PAIRS = 540,
   parameter int ABITS = 10
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               valid_i,
   input  logic               last_i,
   input  logic [WIDTH-1:0]   revis_i,
   input  logic [WIDTH-1:0]   imvis_i,
   vis_frame_buffer_if.master m_axis,
   output logic               drop_o,
   output logic               err_o
);
   localparam logic [ABITS-1:0] LAST_IDX = ABITS'(PAIRS - 1);

   typedef enum logic [1:0] {IDLE, HDR, RE, IM} state_t;

   logic [2*WIDTH-1:0] mem0 [2**ABITS];
   logic [2*WIDTH-1:0] mem1 [2**ABITS];
   logic [2*WIDTH-1:0] rd_q;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] tdata_q, tdata_d, im_q, im_d;
   logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic [ABITS-1:0] rk_q, rk_d, raddr, windex_q;
   logic [15:0]      seq_q;
   logic [7:0]       drop_cnt_q, drop_cnt_d, cnt_left;
   logic             fill_q, rbank_q, lost_q;
   logic [1:0]       full_q, full_d;
   logic             free_rd, hdr_hs;
   logic             frame_last, bank_ok, frame_end, bad, accept, drop, wr_en;

   assign m_axis.m_tdata  = tdata_q;
   assign m_axis.m_tvalid = tvalid_q;
   assign m_axis.m_tlast  = tlast_q;

   // A bank being drained out in this very cycle is already writable.
   always_comb begin
      frame_last = (windex_q == LAST_IDX);
      bank_ok    = !full_q[fill_q] || (free_rd && (rbank_q == fill_q));
      frame_end  = valid_i && last_i && frame_last;
      bad        = valid_i && (last_i != frame_last);
      accept     = frame_end && bank_ok && !lost_q;
      drop       = frame_end && !accept;
      wr_en      = valid_i && bank_ok;
      full_d     = full_q;
      if (free_rd) full_d[rbank_q] = 1'b0;
      if (accept)  full_d[fill_q]  = 1'b1;
   end

   // Prefetch one pair ahead of the output register; the im half waits in im_q.
   assign raddr = (state_q == RE || state_q == IM) ? rk_q + 1'b1 : '0;

   always_ff @(posedge clock) begin
      if (wr_en && fill_q)  mem1[windex_q] <= {revis_i, imvis_i};
      if (wr_en && !fill_q) mem0[windex_q] <= {revis_i, imvis_i};
      rd_q <= rbank_q ? mem1[raddr] : mem0[raddr];
   end

   always_comb begin
      state_d  = state_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      rk_d     = rk_q;
      im_d     = im_q;
      free_rd  = 1'b0;
      hdr_hs   = 1'b0;
      unique case (state_q)
         IDLE: if (full_q[rbank_q]) begin
            state_d  = HDR;
            tdata_d  = WIDTH'({drop_cnt_q, seq_q});
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
         end
         HDR: if (m_axis.m_tready) begin
            hdr_hs  = 1'b1;
            state_d = RE;
            tdata_d = rd_q[2*WIDTH-1:WIDTH];
            im_d    = rd_q[WIDTH-1:0];
            rk_d    = '0;
         end
         RE: if (m_axis.m_tready) begin
            state_d = IM;
            tdata_d = im_q;
            tlast_d = (rk_q == LAST_IDX);
         end
         IM: if (m_axis.m_tready) begin
            tlast_d = 1'b0;
            if (rk_q == LAST_IDX) begin
               state_d  = IDLE;
               tvalid_d = 1'b0;
               free_rd  = 1'b1;
            end else begin
               state_d = RE;
               tdata_d = rd_q[2*WIDTH-1:WIDTH];
               im_d    = rd_q[WIDTH-1:0];
               rk_d    = rk_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Only the drops actually reported in the outgoing header are retired.
   always_comb begin
      cnt_left   = drop_cnt_q - (hdr_hs ? tdata_q[23:16] : 8'd0);
      drop_cnt_d = (drop && cnt_left != 8'hFF) ? cnt_left + 8'd1 : cnt_left;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         rk_q       <= '0;
         im_q       <= '0;
         seq_q      <= '0;
         drop_cnt_q <= '0;
         windex_q   <= '0;
         fill_q     <= 1'b0;
         rbank_q    <= 1'b0;
         full_q     <= '0;
         lost_q     <= 1'b0;
         drop_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         rk_q       <= rk_d;
         im_q       <= im_d;
         drop_cnt_q <= drop_cnt_d;
         full_q     <= full_d;
         drop_o     <= drop;
         err_o      <= bad;
         if (hdr_hs)  seq_q   <= seq_q + 16'd1;
         if (free_rd) rbank_q <= ~rbank_q;
         if (accept)  fill_q  <= ~fill_q;
         if (valid_i) begin
            windex_q <= (frame_end || bad) ? '0 : windex_q + 1'b1;
            // Any pair refused for lack of a bank poisons the rest of the frame.
            if (frame_end || bad) lost_q <= 1'b0;
            else if (!bank_ok)    lost_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vis_frame_buffer.sv
// tb/tb_vis_frame_buffer.sv - directed bench for vis_frame_buffer with PAIRS=4
module tb_vis_frame_buffer;
   localparam int WIDTH = 36;
   localparam int PAIRS = 4;
   localparam int ABITS = 2;

   logic             clock   = 1'b0;
   logic             reset_n = 1'b0;
   logic             valid_i = 1'b0;
   logic             last_i  = 1'b0;
   logic [WIDTH-1:0] revis_i = '0;
   logic [WIDTH-1:0] imvis_i = '0;
   logic             drop_o, err_o;

   vis_frame_buffer_if #(.WIDTH(WIDTH)) axis ();

   vis_frame_buffer #(.WIDTH(WIDTH), .PAIRS(PAIRS), .ABITS(ABITS)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .valid_i (valid_i),
      .last_i  (last_i),
      .revis_i (revis_i),
      .imvis_i (imvis_i),
      .m_axis  (axis),
      .drop_o  (drop_o),
      .err_o   (err_o)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // 0: ready low, 1: ready high, 2: random
   int rdy_mode = 0;
   always @(posedge clock) begin
      #1;
      case (rdy_mode)
         0:       axis.m_tready = 1'b0;
         1:       axis.m_tready = 1'b1;
         default: axis.m_tready = 1'($urandom_range(0, 1));
      endcase
   end

   int cyc = 0;
   always @(posedge clock) cyc++;

   logic [WIDTH:0] beats[$];
   int             stamps[$];
   int             drops = 0;
   int             errs  = 0;
   logic           stalled = 1'b0;
   logic [WIDTH:0] held;

   always @(negedge clock) begin
      if (!reset_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 64'(axis.m_tvalid), 64'd1);
            check("stall_word", 64'({axis.m_tlast, axis.m_tdata}), 64'(held));
         end
         if (axis.m_tvalid && axis.m_tready === 1'b1) begin
            beats.push_back({axis.m_tlast, axis.m_tdata});
            stamps.push_back(cyc);
         end
         stalled = axis.m_tvalid && (axis.m_tready !== 1'b1);
         held    = {axis.m_tlast, axis.m_tdata};
         if (drop_o) drops++;
         if (err_o)  errs++;
      end
   end

   task automatic send_frame(input int n, input int last_at, input int base);
      for (int k = 0; k < n; k++) begin
         valid_i = 1'b1;
         last_i  = (k == last_at);
         revis_i = WIDTH'(base + k + 1);
         imvis_i = WIDTH'(base + 100 + k);
         @(posedge clock);
         #1;
      end
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      int c = 0;
      while (beats.size() < n && c < budget) begin
         @(negedge clock);
         #1;
         c++;
      end
      check({tag, "_beats_arrived"}, 64'(beats.size() >= n), 64'd1);
   endtask

   task automatic check_packet(input string tag, input logic [WIDTH-1:0] hdr, input int base);
      logic [WIDTH:0] exp, got;
      for (int i = 0; i < 2*PAIRS + 1; i++) begin
         if (i == 0)          exp = {1'b0, hdr};
         else if (i % 2 == 1) exp = {1'b0, WIDTH'(base + (i - 1)/2 + 1)};
         else                 exp = {(i == 2*PAIRS), WIDTH'(base + 100 + (i - 2)/2)};
         got = (beats.size() != 0) ? beats.pop_front() : '1;
         stamps.delete(0);
         check($sformatf("%s_beat%0d", tag, i), 64'(got), 64'(exp));
      end
   endtask

   initial begin
      int lat, d0, e0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_tvalid", 64'(axis.m_tvalid), 64'd0);
      check("rst_tlast",  64'(axis.m_tlast),  64'd0);
      check("rst_tdata",  64'(axis.m_tdata),  64'd0);
      check("rst_drop",   64'(drop_o),        64'd0);
      check("rst_err",    64'(err_o),         64'd0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      rdy_mode = 1;
      send_frame(4, 3, 0);
      lat = 0;
      while (!axis.m_tvalid && lat < 10) begin
         @(negedge clock);
         lat++;
      end
      check("hdr_latency", 64'(lat <= 3), 64'd1);
      wait_beats("single", 9, 50);
      if (stamps.size() >= 9) check("single_burst", 64'(stamps[8] - stamps[0]), 64'd8);
      check_packet("single", 36'h0, 0);

      rdy_mode = 2;
      send_frame(4, 3, 0);
      wait_beats("bp", 9, 300);
      check_packet("bp", 36'h1, 0);
      check("bp_drops", 64'(drops), 64'd0);
      check("bp_errs",  64'(errs),  64'd0);

      rdy_mode = 1;
      idle(4);
      rdy_mode = 0;
      idle(2);
      d0 = drops;
      send_frame(4, 3, 'h10);
      send_frame(4, 3, 'h20);
      send_frame(4, 3, 'h30);
      idle(6);
      check("ovf_drop_pulses", 64'(drops - d0), 64'd1);
      check("ovf_no_beats",    64'(beats.size()), 64'd0);
      check("ovf_hdr_waiting", 64'(axis.m_tvalid), 64'd1);
      rdy_mode = 1;
      wait_beats("ovf", 18, 100);
      if (stamps.size() >= 10) check("ovf_gap", 64'(stamps[9] - stamps[8] <= 3), 64'd1);
      check_packet("ovf_a", 36'h0_0002, 'h10);
      check_packet("ovf_b", 36'h1_0003, 'h20);
      idle(10);
      check("ovf_third_gone", 64'(beats.size()), 64'd0);

      e0 = errs;
      send_frame(3, 2, 'h70);
      idle(10);
      check("early_err",      64'(errs - e0), 64'd1);
      check("early_no_beats", 64'(beats.size()), 64'd0);
      send_frame(4, 3, 'h40);
      wait_beats("early_next", 9, 50);
      check_packet("early_next", 36'h4, 'h40);

      e0 = errs;
      send_frame(4, -1, 'h80);
      idle(10);
      check("nolast_err",      64'(errs - e0), 64'd1);
      check("nolast_no_beats", 64'(beats.size()), 64'd0);
      send_frame(4, 3, 'h50);
      wait_beats("nolast_next", 9, 50);
      check_packet("nolast_next", 36'h5, 'h50);
      check("drops_total", 64'(drops), 64'd1);

      send_frame(4, 3, 'h90);
      wait_beats("rstpkt", 3, 50);
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_mid_tvalid", 64'(axis.m_tvalid), 64'd0);
      check("rst_mid_tlast",  64'(axis.m_tlast),  64'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      beats.delete();
      stamps.delete();
      idle(2);
      send_frame(4, 3, 'h60);
      wait_beats("after_rst", 9, 50);
      check_packet("after_rst", 36'h0, 'h60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
